// File: rtl/hpdcache_mem_write_responder.sv
// Memory-side responder for HPDcache write packets: one packet at a time, every flit forwarded
// to a word-wide storage write port, one {id, error} response queued per packet.
module hpdcache_mem_write_responder #(
  parameter int unsigned AddrWidth     = 49,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned IdWidth       = 4,
  parameter int unsigned LenWidth      = 8,
  parameter int unsigned RespFifoDepth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  output logic                     mem_req_write_ready_o,
  input  logic                     mem_req_write_valid_i,
  input  logic [AddrWidth-1:0]     mem_req_write_addr_i,
  input  logic [LenWidth-1:0]      mem_req_write_len_i,
  input  logic [IdWidth-1:0]       mem_req_write_id_i,
  output logic                     mem_req_write_data_ready_o,
  input  logic                     mem_req_write_data_valid_i,
  input  logic [DataWidth-1:0]     mem_req_write_data_i,
  input  logic [DataWidth/8-1:0]   mem_req_write_be_i,
  input  logic                     mem_req_write_last_i,
  input  logic                     mem_resp_write_ready_i,
  output logic                     mem_resp_write_valid_o,
  output logic [IdWidth-1:0]       mem_resp_write_id_o,
  output logic                     mem_resp_write_error_o,
  output logic                     store_w_o,
  output logic [AddrWidth-1:0]     store_addr_o,
  output logic [DataWidth-1:0]     store_data_o,
  output logic [DataWidth/8-1:0]   store_be_o
);

  localparam int unsigned BeWidth  = DataWidth / 8;
  localparam int unsigned OffWidth = $clog2(BeWidth);
  localparam int unsigned PtrWidth = (RespFifoDepth > 1) ? $clog2(RespFifoDepth) : 1;
  localparam int unsigned CntWidth = $clog2(RespFifoDepth + 1);

  typedef enum logic [0:0] {StIdle, StData} state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   base_q, base_d;
  logic [LenWidth-1:0]    len_q, len_d;
  logic [IdWidth-1:0]     id_q, id_d;
  logic [AddrWidth-1:0]   cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic                   push, pop, push_err;
  logic                   fifo_full;
  logic [IdWidth:0]       fifo_q [RespFifoDepth];
  logic [PtrWidth-1:0]    wptr_q, rptr_q;
  logic [CntWidth-1:0]    count_q;
  logic                   flit_hs;

  assign fifo_full = (count_q == CntWidth'(RespFifoDepth));
  assign flit_hs   = (state_q == StData) && mem_req_write_data_valid_i;

  always_comb begin
    state_d                    = state_q;
    base_d                     = base_q;
    len_d                      = len_q;
    id_d                       = id_q;
    cnt_d                      = cnt_q;
    err_d                      = err_q;
    push                       = 1'b0;
    push_err                   = 1'b0;
    mem_req_write_ready_o      = 1'b0;
    mem_req_write_data_ready_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        mem_req_write_ready_o = ~fifo_full;
        if (mem_req_write_valid_i && !fifo_full) begin
          base_d  = (mem_req_write_addr_i >> OffWidth) << OffWidth;
          len_d   = mem_req_write_len_i;
          id_d    = mem_req_write_id_i;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = StData;
        end
      end
      StData: begin
        mem_req_write_data_ready_o = 1'b1;
        if (mem_req_write_data_valid_i) begin
          cnt_d = cnt_q + AddrWidth'(1);
          if (mem_req_write_last_i) begin
            push     = 1'b1;
            push_err = (cnt_q != AddrWidth'(len_q)) | err_q;
            state_d  = StIdle;
          end else if (cnt_q == AddrWidth'(len_q)) begin
            // Overrun: more flits than announced; the flit is still written.
            err_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      base_q  <= '0;
      len_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign store_w_o    = flit_hs;
  assign store_addr_o = base_q + (cnt_q << OffWidth);
  assign store_data_o = mem_req_write_data_i;
  assign store_be_o   = mem_req_write_be_i;

  // Response FIFO: registered storage, so a push becomes visible one cycle later.
  assign mem_resp_write_valid_o = (count_q != '0);
  assign pop                    = mem_resp_write_valid_o & mem_resp_write_ready_i;
  assign mem_resp_write_id_o    = fifo_q[rptr_q][IdWidth:1];
  assign mem_resp_write_error_o = fifo_q[rptr_q][0];

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wptr_q] <= {id_q, push_err};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= (wptr_q == PtrWidth'(RespFifoDepth - 1)) ? '0 : wptr_q + PtrWidth'(1);
      end
      if (pop) begin
        rptr_q <= (rptr_q == PtrWidth'(RespFifoDepth - 1)) ? '0 : rptr_q + PtrWidth'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntWidth'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntWidth'(1);
      end
    end
  end

endmodule

// File: tb/tb_hpdcache_mem_write_responder.sv
// Bench for hpdcache_mem_write_responder: directed scenarios plus random packets, all observed
// by a negedge monitor that models addresses, pass-through and the response queue.
module tb_hpdcache_mem_write_responder;

  localparam int unsigned AW = 49;
  localparam int unsigned DW = 64;
  localparam int unsigned IW = 4;
  localparam int unsigned LW = 8;
  localparam int unsigned BW = DW / 8;
  localparam int LIMIT = 300;

  logic          clk, rst_n;
  logic          hdr_ready, hdr_valid;
  logic [AW-1:0] hdr_addr;
  logic [LW-1:0] hdr_len;
  logic [IW-1:0] hdr_id;
  logic          data_ready, data_valid, data_last;
  logic [DW-1:0] data;
  logic [BW-1:0] be;
  logic          resp_ready, resp_valid, resp_err;
  logic [IW-1:0] resp_id;
  logic          store_w;
  logic [AW-1:0] store_addr;
  logic [DW-1:0] store_data;
  logic [BW-1:0] store_be;

  int total = 0;
  int bad   = 0;
  bit rr_rand = 0;
  bit gaps    = 0;

  logic [IW:0]   exp_q[$];
  logic [AW-1:0] mon_base;
  int            mon_len, mon_n;
  logic [IW-1:0] mon_id;
  bit            lat, hold;
  logic [IW-1:0] held_id;
  logic          held_err;

  hpdcache_mem_write_responder dut (
    .clk_i                      (clk),
    .rst_ni                     (rst_n),
    .mem_req_write_ready_o      (hdr_ready),
    .mem_req_write_valid_i      (hdr_valid),
    .mem_req_write_addr_i       (hdr_addr),
    .mem_req_write_len_i        (hdr_len),
    .mem_req_write_id_i         (hdr_id),
    .mem_req_write_data_ready_o (data_ready),
    .mem_req_write_data_valid_i (data_valid),
    .mem_req_write_data_i       (data),
    .mem_req_write_be_i         (be),
    .mem_req_write_last_i       (data_last),
    .mem_resp_write_ready_i     (resp_ready),
    .mem_resp_write_valid_o     (resp_valid),
    .mem_resp_write_id_o        (resp_id),
    .mem_resp_write_error_o     (resp_err),
    .store_w_o                  (store_w),
    .store_addr_o               (store_addr),
    .store_data_o               (store_data),
    .store_be_o                 (store_be)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Monitor and reference model: flit k of a packet lands at aligned base + k*BW (mod 2^AW);
  // a packet errs exactly when its flit count differs from len+1.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        lat  = 0;
        hold = 0;
        check("rst_store_w", store_w, 0);
        check("rst_resp_valid", resp_valid, 0);
      end else begin
        int sz0;
        sz0 = exp_q.size();
        if (lat) check("resp_latency", resp_valid, 1);
        lat = 0;
        if (hold) begin
          check("resp_hold_valid", resp_valid, 1);
          check("resp_hold_id", resp_id, held_id);
          check("resp_hold_err", resp_err, held_err);
        end
        hold     = resp_valid && !resp_ready;
        held_id  = resp_id;
        held_err = resp_err;
        if (resp_valid && resp_ready) begin
          check("resp_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            logic [IW:0] e;
            e = exp_q.pop_front();
            check("resp_id", resp_id, e[IW:1]);
            check("resp_err", resp_err, e[0]);
          end
        end
        check("store_w", store_w, data_valid && data_ready);
        if (data_valid && data_ready) begin
          logic [AW-1:0] ea;
          ea = mon_base + (AW'(mon_n) * AW'(BW));
          check("store_addr", store_addr, ea);
          check("store_data", store_data, data);
          check("store_be", store_be, be);
          mon_n++;
          if (data_last) begin
            if (sz0 == 0) check("resp_no_feedthru", resp_valid, 0);
            exp_q.push_back({mon_id, mon_n != mon_len + 1});
            lat = 1;
          end
        end
        if (hdr_valid && hdr_ready) begin
          mon_base = (hdr_addr / AW'(BW)) * AW'(BW);
          mon_len  = int'(hdr_len);
          mon_id   = hdr_id;
          mon_n    = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rr_rand) resp_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_hdr(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic [IW-1:0] i);
    int w = 0;
    hdr_valid = 1; hdr_addr = a; hdr_len = l; hdr_id = i;
    @(negedge clk);
    while (!hdr_ready && w < LIMIT) begin
      @(negedge clk);
      w++;
    end
    check("hdr_accept", w < LIMIT, 1);
    @(posedge clk); #1;
    hdr_valid = 0;
  endtask

  task automatic send_flit(input logic last);
    int w = 0;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    data_valid = 1; data_last = last;
    data = {$urandom(), $urandom()};
    be   = BW'($urandom());
    @(negedge clk);
    while (!data_ready && w < LIMIT) begin
      @(negedge clk);
      w++;
    end
    check("flit_accept", w < LIMIT, 1);
    @(posedge clk); #1;
    data_valid = 0; data_last = 0;
  endtask

  task automatic send_pkt(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic [IW-1:0] i,
                          input int n);
    send_hdr(a, l, i);
    for (int k = 0; k < n; k++) send_flit(k == n - 1);
  endtask

  task automatic drain();
    int w = 0;
    resp_ready = 1;
    while (exp_q.size() != 0 && w < LIMIT) begin
      @(posedge clk);
      w++;
    end
    #1;
    check("drain", w < LIMIT, 1);
    resp_ready = 0;
  endtask

  initial begin
    rst_n = 0; hdr_valid = 0; hdr_addr = '0; hdr_len = '0; hdr_id = '0;
    data_valid = 0; data = '0; be = '0; data_last = 0; resp_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("reset_hdr_ready", hdr_ready, 1);
    check("reset_data_ready", data_ready, 0);
    check("reset_resp_valid", resp_valid, 0);
    check("reset_store_w", store_w, 0);
    @(posedge clk); #1;

    // Nominal 4-flit packet, then short and long packets.
    send_pkt(AW'(49'h1000), 8'd3, 4'd5, 4);
    drain();
    send_pkt(AW'(49'h2000), 8'd3, 4'd6, 2);
    drain();
    send_pkt(AW'(49'h3004), 8'd1, 4'd7, 3);
    drain();

    // Fill the response FIFO and block the fifth header.
    for (int k = 0; k < 4; k++) send_pkt(AW'(49'h4000 + k * 256), 8'd0, IW'(k), 1);
    hdr_valid = 1; hdr_addr = AW'(49'h4400); hdr_len = 0; hdr_id = 4'd4;
    repeat (3) begin
      @(negedge clk);
      check("full_hdr_block", hdr_ready, 0);
    end
    @(posedge clk); #1 resp_ready = 1;
    @(negedge clk);
    check("full_hdr_block_pop", hdr_ready, 0);
    @(posedge clk); #1 resp_ready = 0;
    @(negedge clk);
    check("hdr_after_pop", hdr_ready, 1);
    @(posedge clk); #1 hdr_valid = 0;
    send_flit(1);
    drain();

    // Flit presented before its header.
    data_valid = 1; data_last = 1; data = 64'hDEAD_BEEF_0123_4567; be = 8'h5A;
    repeat (3) begin
      @(negedge clk);
      check("early_flit_stall", data_ready, 0);
    end
    @(posedge clk); #1;
    send_hdr(AW'(49'h5008), 8'd0, 4'd9);
    @(negedge clk);
    check("early_flit_taken", data_ready & store_w, 1);
    @(posedge clk); #1 data_valid = 0; data_last = 0;
    drain();

    // Reset mid-packet with responses queued.
    send_pkt(AW'(49'h6000), 8'd0, 4'd1, 1);
    send_pkt(AW'(49'h6100), 8'd0, 4'd2, 1);
    send_hdr(AW'(49'h6200), 8'd3, 4'd3);
    send_flit(0);
    send_flit(0);
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("post_rst_resp_valid", resp_valid, 0);
    check("post_rst_hdr_ready", hdr_ready, 1);
    @(posedge clk); #1;
    send_pkt(AW'(49'h7000), 8'd1, 4'hA, 2);
    drain();

    // Random packets with random gaps and response back-pressure, including address wrap.
    rr_rand = 1;
    gaps    = 1;
    for (int p = 0; p < 40; p++) begin
      logic [AW-1:0] a;
      logic [LW-1:0] l;
      int n;
      l = LW'($urandom_range(0, 7));
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : int'(l) + 1;
      a = ($urandom_range(0, 4) == 0) ? AW'(49'h1_FFFF_FFFF_FFE3) : AW'({$urandom(), $urandom()});
      send_pkt(a, l, IW'($urandom()), n);
    end
    rr_rand = 0;
    gaps    = 0;
    @(posedge clk); #1;
    drain();
    @(negedge clk);
    check("final_resp_valid", resp_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
